hp_burst_engine: RTL and testbench

- Sequencer for the kernel's AXI4 high-performance master port.
- On a start pulse from the host register file, walks the byte range [start_addr, end_addr) in 16-byte beats.
- In write mode it fills the range with an arithmetic value sequence. In read mode it reads the range back and accumulates a 32-bit checksum.
- Sits between the host register block (configuration, start, state) and the hp_* AXI master interface. It owns all hp_* outputs.

---
 rtl/hp_burst_engine.sv | 190 +++++++++++++++++++
 tb/tb_hp_burst_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_burst_engine.sv
// AXI4 HP-port burst sequencer: fills [start_addr, end_addr) with an arithmetic
// sequence (write mode) or reads it back into a 32-bit checksum (read mode).
`timescale 1ns/1ps
module hp_burst_engine #(
    parameter int HP_ADDR_WIDTH = 48,
    parameter int HP_DATA_WIDTH = 128,
    parameter int MAX_BURST     = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       abort,
    input  logic [63:0]                start_addr,
    input  logic [63:0]                end_addr,
    input  logic [HP_DATA_WIDTH-1:0]   start_value,
    input  logic [HP_DATA_WIDTH-1:0]   value_stride,
    input  logic                       benchmode,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [31:0]                checksum,
    output logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
    output logic [7:0]                 hp_awlen,
    output logic [2:0]                 hp_awsize,
    output logic [1:0]                 hp_awburst,
    output logic                       hp_awvalid,
    input  logic                       hp_awready,
    output logic [HP_DATA_WIDTH-1:0]   hp_wdata,
    output logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
    output logic                       hp_wlast,
    output logic                       hp_wvalid,
    input  logic                       hp_wready,
    input  logic [1:0]                 hp_bresp,
    input  logic                       hp_bvalid,
    output logic                       hp_bready,
    output logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
    output logic [7:0]                 hp_arlen,
    output logic [2:0]                 hp_arsize,
    output logic [1:0]                 hp_arburst,
    output logic                       hp_arvalid,
    input  logic                       hp_arready,
    input  logic [HP_DATA_WIDTH-1:0]   hp_rdata,
    input  logic [1:0]                 hp_rresp,
    input  logic                       hp_rlast,
    input  logic                       hp_rvalid,
    output logic                       hp_rready
);
    localparam int BW  = HP_ADDR_WIDTH - 4;
    localparam int NDW = HP_DATA_WIDTH / 32;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_ADDR, S_WDATA, S_WRESP, S_RDATA, S_DONE
    } state_t;

    state_t                     r_state, w_next;
    logic [BW-1:0]              r_cur, r_last;
    logic [8:0]                 r_len, r_beat;
    logic [HP_DATA_WIDTH-1:0]   r_val, r_stride;
    logic                       r_mode, r_abort, r_error;
    logic [31:0]                r_checksum;

    logic [BW-1:0]              w_diff;
    logic [8:0]                 w_rem, w_to4k, w_len;
    logic [31:0]                w_dw_sum;
    logic                       w_wlast;
    logic                       w_unused_bits;

    assign w_unused_bits = ^{start_addr[63:HP_ADDR_WIDTH], start_addr[3:0],
                             end_addr[63:HP_ADDR_WIDTH], end_addr[3:0]};

    // Burst length: min of MAX_BURST, beats remaining, beats to the 4 KB page end.
    assign w_diff = r_last - r_cur;
    assign w_rem  = (w_diff > BW'(256)) ? 9'd256 : w_diff[8:0];
    assign w_to4k = 9'd256 - {1'b0, r_cur[7:0]};
    always_comb begin
        w_len = 9'(MAX_BURST);
        if (w_rem < w_len)  w_len = w_rem;
        if (w_to4k < w_len) w_len = w_to4k;
    end

    always_comb begin
        w_dw_sum = '0;
        for (int i = 0; i < NDW; i++) w_dw_sum = w_dw_sum + hp_rdata[32*i +: 32];
    end

    assign w_wlast    = (r_beat == r_len - 9'd1);
    assign hp_awaddr  = {r_cur, 4'b0000};
    assign hp_araddr  = {r_cur, 4'b0000};
    assign hp_awlen   = 8'(r_len - 9'd1);
    assign hp_arlen   = 8'(r_len - 9'd1);
    assign hp_awsize  = 3'd4;
    assign hp_arsize  = 3'd4;
    assign hp_awburst = 2'b01;
    assign hp_arburst = 2'b01;
    assign hp_wstrb   = '1;
    assign hp_wdata   = r_val;
    assign hp_wlast   = w_wlast;
    assign error      = r_error;
    assign checksum   = r_checksum;

    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        done       = 1'b0;
        hp_awvalid = 1'b0;
        hp_arvalid = 1'b0;
        hp_wvalid  = 1'b0;
        hp_bready  = 1'b0;
        hp_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_CALC;
            end
            S_CALC: w_next = (r_cur >= r_last || r_abort || abort) ? S_DONE : S_ADDR;
            S_ADDR: begin
                hp_awvalid = !r_mode;
                hp_arvalid = r_mode;
                if (r_mode ? hp_arready : hp_awready) w_next = r_mode ? S_RDATA : S_WDATA;
            end
            S_WDATA: begin
                hp_wvalid = 1'b1;
                if (hp_wready && w_wlast) w_next = S_WRESP;
            end
            S_WRESP: begin
                hp_bready = 1'b1;
                if (hp_bvalid) w_next = S_CALC;
            end
            S_RDATA: begin
                hp_rready = 1'b1;
                if (hp_rvalid && hp_rlast) w_next = S_CALC;
            end
            S_DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_last     <= '0;
            r_len      <= 9'd1;
            r_beat     <= '0;
            r_val      <= '0;
            r_stride   <= '0;
            r_mode     <= 1'b0;
            r_abort    <= 1'b0;
            r_error    <= 1'b0;
            r_checksum <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != S_IDLE && abort) r_abort <= 1'b1;
            case (r_state)
                S_IDLE: if (start) begin
                    r_cur      <= start_addr[HP_ADDR_WIDTH-1:4];
                    r_last     <= end_addr[HP_ADDR_WIDTH-1:4];
                    r_val      <= start_value;
                    r_stride   <= value_stride;
                    r_mode     <= benchmode;
                    r_abort    <= 1'b0;
                    r_error    <= 1'b0;
                    r_checksum <= '0;
                end
                S_CALC: begin
                    r_len  <= w_len;
                    r_beat <= '0;
                end
                S_WDATA: if (hp_wready) begin
                    r_val  <= r_val + r_stride;
                    r_beat <= r_beat + 9'd1;
                end
                S_WRESP: if (hp_bvalid) begin
                    r_error <= r_error | (hp_bresp != 2'b00);
                    r_cur   <= r_cur + BW'(r_len);
                end
                S_RDATA: if (hp_rvalid) begin
                    r_checksum <= r_checksum + w_dw_sum;
                    r_error    <= r_error | (hp_rresp != 2'b00);
                    if (hp_rlast) r_cur <= r_cur + BW'(r_len);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hp_burst_engine.sv
// Scoreboard bench for hp_burst_engine: a reactive AXI slave checks every
// address and write beat against expectations queued when each run is started.
`timescale 1ns/1ps
module tb_hp_burst_engine;
    typedef struct packed {
        logic [47:0] addr;
        logic [7:0]  len;
    } burst_t;

    logic          clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, benchmode = 1'b0;
    logic [63:0]   start_addr = '0, end_addr = '0;
    logic [127:0]  start_value = '0, value_stride = '0;
    logic          busy, done, error;
    logic [31:0]   checksum;
    logic [47:0]   hp_awaddr, hp_araddr;
    logic [7:0]    hp_awlen, hp_arlen;
    logic [2:0]    hp_awsize, hp_arsize;
    logic [1:0]    hp_awburst, hp_arburst;
    logic          hp_awvalid, hp_arvalid, hp_wvalid, hp_wlast, hp_bready, hp_rready;
    logic [127:0]  hp_wdata;
    logic [15:0]   hp_wstrb;
    logic          hp_awready = 1'b1, hp_arready = 1'b1, hp_wready = 1'b0;
    logic          hp_bvalid = 1'b0, hp_rvalid = 1'b0, hp_rlast = 1'b0;
    logic [1:0]    hp_bresp = '0, hp_rresp = '0;
    logic [127:0]  hp_rdata = '0;

    int n_checks = 0, n_errors = 0;
    burst_t        exp_a[$];
    logic [128:0]  exp_w[$];

    logic          sl_bp = 1'b0, sl_err_first = 1'b0, sl_rnd = 1'b0, sl_b_pend = 1'b0;
    int            sl_b_idx = 0, sl_r_left = 0, sl_n_addr = 0, sl_valid_seen = 0;
    logic [31:0]   sl_sum = '0;

    always #5 clk = ~clk;

    hp_burst_engine #(.HP_ADDR_WIDTH(48), .HP_DATA_WIDTH(128), .MAX_BURST(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr),
        .start_value(start_value), .value_stride(value_stride), .benchmode(benchmode),
        .busy(busy), .done(done), .error(error), .checksum(checksum),
        .hp_awaddr(hp_awaddr), .hp_awlen(hp_awlen), .hp_awsize(hp_awsize),
        .hp_awburst(hp_awburst), .hp_awvalid(hp_awvalid), .hp_awready(hp_awready),
        .hp_wdata(hp_wdata), .hp_wstrb(hp_wstrb), .hp_wlast(hp_wlast),
        .hp_wvalid(hp_wvalid), .hp_wready(hp_wready),
        .hp_bresp(hp_bresp), .hp_bvalid(hp_bvalid), .hp_bready(hp_bready),
        .hp_araddr(hp_araddr), .hp_arlen(hp_arlen), .hp_arsize(hp_arsize),
        .hp_arburst(hp_arburst), .hp_arvalid(hp_arvalid), .hp_arready(hp_arready),
        .hp_rdata(hp_rdata), .hp_rresp(hp_rresp), .hp_rlast(hp_rlast),
        .hp_rvalid(hp_rvalid), .hp_rready(hp_rready)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference burst split: MAX_BURST 16, never past the range end or a 4 KB page.
    task automatic push_expect(input logic [63:0] sa, ea, input logic [127:0] sv, st,
                               input logic mode, input int maxb, output int nb);
        logic [43:0]  c, l;
        logic [127:0] v;
        int           rem, to4k, lenb;
        c = sa[47:4];
        l = ea[47:4];
        v = sv;
        nb = 0;
        while (c < l && nb < maxb) begin
            rem  = (l - c > 44'd256) ? 256 : int'(l - c);
            to4k = 256 - int'(c[7:0]);
            lenb = 16;
            if (rem < lenb)  lenb = rem;
            if (to4k < lenb) lenb = to4k;
            exp_a.push_back('{addr: {c, 4'b0000}, len: 8'(lenb - 1)});
            if (!mode) begin
                for (int j = 0; j < lenb; j++) begin
                    exp_w.push_back({(j == lenb - 1), v});
                    v = v + st;
                end
            end
            c = c + 44'(lenb);
            nb++;
        end
    endtask

    initial begin : slave_model
        logic         n_wready, n_bvalid, n_rvalid, n_rlast;
        logic [1:0]   n_bresp;
        logic [127:0] n_rdata;
        burst_t       b;
        logic [128:0] w;
        forever begin
            @(negedge clk);
            n_wready = hp_wready; n_bvalid = hp_bvalid; n_bresp = hp_bresp;
            n_rvalid = hp_rvalid; n_rlast = hp_rlast; n_rdata = hp_rdata;
            if (!rstn) begin
                sl_b_pend = 1'b0; sl_r_left = 0;
                n_wready = 1'b0; n_bvalid = 1'b0; n_bresp = '0; n_rvalid = 1'b0; n_rlast = 1'b0;
            end else begin
                if (hp_awvalid || hp_arvalid) sl_valid_seen++;
                if ((hp_awvalid && hp_awready) || (hp_arvalid && hp_arready)) begin
                    sl_n_addr++;
                    if (exp_a.size() == 0) check_eq("addr_unexpected", 1, 0);
                    else begin
                        b = exp_a.pop_front();
                        if (hp_awvalid) begin
                            check_eq("awaddr", hp_awaddr, b.addr);
                            check_eq("awlen", hp_awlen, b.len);
                        end else begin
                            check_eq("araddr", hp_araddr, b.addr);
                            check_eq("arlen", hp_arlen, b.len);
                            sl_r_left = int'(hp_arlen) + 1;
                        end
                    end
                end
                if (hp_wvalid && hp_wready) begin
                    if (exp_w.size() == 0) check_eq("w_unexpected", 1, 0);
                    else begin
                        w = exp_w.pop_front();
                        check_eq("wdata", hp_wdata, w[127:0]);
                        check_eq("wlast", hp_wlast, w[128]);
                    end
                    if (hp_wlast) sl_b_pend = 1'b1;
                end
                if (hp_bvalid && hp_bready) begin
                    n_bvalid = 1'b0;
                    sl_b_idx++;
                end
                if (sl_b_pend) begin
                    n_bvalid  = 1'b1;
                    n_bresp   = (sl_err_first && sl_b_idx == 0) ? 2'd2 : 2'd0;
                    sl_b_pend = 1'b0;
                end
                if (hp_rvalid && hp_rready && sl_r_left > 0) begin
                    for (int k = 0; k < 4; k++) sl_sum = sl_sum + hp_rdata[32*k +: 32];
                    sl_r_left--;
                end
                if (sl_r_left > 0 && (!hp_rvalid || hp_rready)) begin
                    n_rvalid = 1'b1;
                    n_rdata  = sl_rnd ? {$urandom, $urandom, $urandom, $urandom} : {4{32'h1}};
                    n_rlast  = (sl_r_left == 1);
                end else if (sl_r_left == 0) begin
                    n_rvalid = 1'b0;
                    n_rlast  = 1'b0;
                end
                n_wready = sl_bp ? !hp_wready : 1'b1;
            end
            @(posedge clk);
            #1;
            hp_wready = n_wready; hp_bvalid = n_bvalid; hp_bresp = n_bresp;
            hp_rvalid = n_rvalid; hp_rlast = n_rlast; hp_rdata = n_rdata;
        end
    end

    task automatic run_test(input string tag, input logic [63:0] sa, ea,
                            input logic [127:0] sv, st, input logic mode,
                            input logic bp, ef, rnd, ab_start, ab_mode,
                            input int maxb, input logic exp_err, input int exp_lat);
        int   nb, lat;
        logic got_done, raise_now, raised, busy_early, busy_at_done;
        sl_bp = bp; sl_err_first = ef; sl_rnd = rnd;
        sl_sum = '0; sl_n_addr = 0; sl_valid_seen = 0; sl_b_idx = 0;
        exp_a.delete(); exp_w.delete();
        push_expect(sa, ea, sv, st, mode, maxb, nb);
        got_done = 1'b0; raise_now = 1'b0; raised = 1'b0; lat = -1;
        busy_early = 1'b0; busy_at_done = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; abort = ab_start;
        start_addr = sa; end_addr = ea; start_value = sv; value_stride = st; benchmode = mode;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = (bp && i == 4);
            abort = raise_now;
            raise_now = 1'b0;
            @(negedge clk);
            if (i == 0) busy_early = busy;
            if (ab_mode && !raised && hp_wvalid) begin
                raise_now = 1'b1;
                raised = 1'b1;
            end
            if (done) begin
                got_done = 1'b1;
                lat = i;
                busy_at_done = busy;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check_eq({tag, "_done"}, got_done, 1);
        check_eq({tag, "_busy_early"}, busy_early, 1);
        check_eq({tag, "_busy_at_done"}, busy_at_done, 0);
        if (exp_lat >= 0) check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_error"}, error, exp_err);
        check_eq({tag, "_checksum"}, checksum, mode ? sl_sum : 32'h0);
        check_eq({tag, "_bursts"}, sl_n_addr, nb);
        check_eq({tag, "_addr_left"}, exp_a.size(), 0);
        check_eq({tag, "_w_left"}, exp_w.size(), 0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin : main
        logic seen;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valids", {hp_awvalid, hp_arvalid, hp_wvalid, hp_bready, hp_rready}, 0);
        check_eq("rst_awsize", hp_awsize, 3'd4);
        check_eq("rst_arburst", hp_arburst, 2'b01);
        check_eq("rst_wstrb", hp_wstrb, 16'hFFFF);
        check_eq("rst_checksum", checksum, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_test("wr_basic", 64'h1000, 64'h1100, 128'd0, 128'd1, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1'b0, -1);
        run_test("wr_4k", 64'hFFFF_0000_0000_1FC0, 64'h2040, 128'd0, 128'd1, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100, 1'b0, -1);
        run_test("rd_ones", 64'h0, 64'h200, 128'd0, 128'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1'b0, -1);
        check_eq("rd_ones_const", checksum, 32'h80);
        run_test("empty", 64'h4000, 64'h4000, 128'd0, 128'd1, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1'b0, 1);
        check_eq("empty_no_valid", sl_valid_seen, 0);
        run_test("bp_err", 64'h0, 64'h300, 128'h1234, {64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 100, 1'b1, -1);
        run_test("rd_rand", 64'h3040, 64'h3180, 128'd0, 128'd0, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 100, 1'b0, -1);
        run_test("abort", 64'h0, 64'h400, 128'd7, 128'd2, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, -1);

        sl_bp = 1'b0; sl_err_first = 1'b0;
        exp_a.delete(); exp_w.delete();
        begin
            int nb;
            push_expect(64'h1000, 64'h1100, 128'd0, 128'd1, 1'b0, 100, nb);
        end
        @(posedge clk); #1;
        start = 1'b1; start_addr = 64'h1000; end_addr = 64'h1100;
        start_value = '0; value_stride = 128'd1; benchmode = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (hp_wvalid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rst_reach_wdata", seen, 1);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_valids", {hp_awvalid, hp_arvalid, hp_wvalid, hp_bready, hp_rready, done}, 0);
        check_eq("arst_sizes", {hp_awsize, hp_arsize, hp_awburst}, {3'd4, 3'd4, 2'b01});
        repeat (2) @(negedge clk);
        exp_a.delete(); exp_w.delete();
        #2 rstn = 1'b1;
        repeat (2) @(negedge clk);
        run_test("post_rst", 64'h1000, 64'h1100, 128'd5, 128'd3, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
